// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame constants, and compile-time helpers
// used by both the buffered transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Bit period in clock cycles; truncation matches the receiver's sampling grid.
   function automatic int baud_div(input int clock_hz, input int baud);
      return clock_hz / baud;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO: dout always shows the head entry, so a
// consumer can pop and use the byte in the same cycle.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk100,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [clog2(DEPTH):0]  count,
   output logic                   full,
   output logic                   empty
);

   localparam int              AW       = clog2(DEPTH);
   localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees the slot being written, so a full FIFO still accepts a simultaneous push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk100) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: WR strobes queue bytes in a FIFO; the serialiser
// drains it LSB first with back-to-back frames and no idle gap between them.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLOCK      = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [DATA_BITS-1:0]        D,
   input  logic                        WR,
   output logic                        TX,
   output logic                        TXE,
   output logic                        FULL,
   output logic [clog2(FIFO_DEPTH):0]  COUNT,
   output logic                        OVF
);

   localparam int                 DIV     = baud_div(CLOCK, BAUD_RATE);
   localparam int                 CNT_W   = (clog2(DIV) > 0) ? clog2(DIV) : 1;
   localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(DIV - 1);
   localparam int                 IDX_W   = clog2(DATA_BITS);
   localparam logic [IDX_W-1:0]   IDX_END = IDX_W'(DATA_BITS - 1);

   uart_state_t           state;
   uart_state_t           state_nx;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic [DATA_BITS-1:0]  shift;
   logic                  tx_nx;
   logic                  bit_end;
   logic                  shift_adv;
   logic                  idx_clr;
   logic                  idx_inc;
   logic                  fifo_pop;
   logic                  fifo_empty;
   logic [DATA_BITS-1:0]  fifo_dout;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk100 (CLK),
      .rst_n  (RST_N),
      .push   (WR),
      .pop    (fifo_pop),
      .din    (D),
      .dout   (fifo_dout),
      .count  (COUNT),
      .full   (FULL),
      .empty  (fifo_empty)
   );

   assign bit_end = (cnt == CNT_END);
   assign TXE     = (state == ST_IDLE) && fifo_empty;

   always_comb begin
      state_nx  = state;
      tx_nx     = TX;
      fifo_pop  = 1'b0;
      shift_adv = 1'b0;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_nx = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               tx_nx    = 1'b0;
               state_nx = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               tx_nx     = shift[0];
               shift_adv = 1'b1;
               idx_clr   = 1'b1;
               state_nx  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (idx == IDX_END) begin
                  tx_nx    = 1'b1;
                  state_nx = ST_STOP;
               end else begin
                  tx_nx     = shift[0];
                  shift_adv = 1'b1;
                  idx_inc   = 1'b1;
               end
            end
         end
         ST_STOP: begin
            // Chain straight into the next start bit when more bytes are queued.
            if (bit_end) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  tx_nx    = 1'b0;
                  state_nx = ST_START;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
         TX    <= 1'b1;
         cnt   <= '0;
         OVF   <= 1'b0;
      end else begin
         state <= state_nx;
         TX    <= tx_nx;
         if (state == ST_IDLE || bit_end) cnt <= '0;
         else                             cnt <= cnt + 1'b1;
         if (WR && FULL && !fifo_pop)     OVF <= 1'b1;
      end
   end

   // Datapath registers are always (re)loaded before use, so they carry no reset.
   always_ff @(posedge CLK) begin
      if (fifo_pop)       shift <= fifo_dout;
      else if (shift_adv) shift <= shift >> 1;
      if (idx_clr)        idx   <= '0;
      else if (idx_inc)   idx   <= idx + 1'b1;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIV=10: a queue-and-frame-offset line model checked every
// cycle, a mid-bit line decoder, a frame vector table and hand-written corner cases.
module tb_uart_tx_fifo;

   localparam int DIV   = 10;
   localparam int FRAME = 10 * DIV;
   localparam int DEPTH = 16;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic [7:0] D = 8'h00;
   logic       WR = 1'b0;
   logic       TX;
   logic       TXE;
   logic       FULL;
   logic [4:0] COUNT;
   logic       OVF;

   uart_tx_fifo #(
      .CLOCK      (1_000_000),
      .BAUD_RATE  (100_000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .D     (D),
      .WR    (WR),
      .TX    (TX),
      .TXE   (TXE),
      .FULL  (FULL),
      .COUNT (COUNT),
      .OVF   (OVF)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] d;
      logic [9:0] frame;
   } vec_t;

   int total = 0;
   int bad   = 0;

   logic [7:0] q[$];
   logic [7:0] acc_q[$];
   logic [7:0] rx_q[$];
   logic       m_busy = 1'b0;
   int         m_fpos = 0;
   logic [7:0] m_cur = 8'h00;
   logic       m_ovf = 1'b0;

   logic       dec_busy = 1'b0;
   int         dec_n = 0;
   logic [7:0] dec_byte = 8'h00;

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      q.delete();
      acc_q.delete();
      rx_q.delete();
      m_busy   = 1'b0;
      m_fpos   = 0;
      m_ovf    = 1'b0;
      dec_busy = 1'b0;
      dec_n    = 0;
   endfunction

   function automatic void model_step(input logic wr, input logic [7:0] d);
      logic pop;
      pop = (q.size() > 0) && (!m_busy || m_fpos == FRAME - 1);
      if (pop) m_cur = q.pop_front();
      if (wr) begin
         if (q.size() < DEPTH) begin
            q.push_back(d);
            acc_q.push_back(d);
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (pop) begin
         m_busy = 1'b1;
         m_fpos = 0;
      end else if (m_busy) begin
         if (m_fpos == FRAME - 1) m_busy = 1'b0;
         else                     m_fpos++;
      end
   endfunction

   function automatic int model_tx();
      int b;
      if (!m_busy) return 1;
      b = m_fpos / DIV;
      if (b == 0) return 0;
      if (b <= 8) return int'(m_cur[b-1]);
      return 1;
   endfunction

   function automatic void compare_all();
      check("tx", int'(TX), model_tx());
      check("count", int'(COUNT), q.size());
      check("txe", int'(TXE), int'(!m_busy && q.size() == 0));
      check("full", int'(FULL), int'(q.size() == DEPTH));
      check("ovf", int'(OVF), int'(m_ovf));
   endfunction

   function automatic void decode();
      int b;
      if (!dec_busy) begin
         if (TX == 1'b0) begin
            dec_busy = 1'b1;
            dec_n    = 0;
         end
      end else begin
         dec_n++;
         if (dec_n % DIV == DIV / 2) begin
            b = dec_n / DIV;
            if (b == 0) begin
               check("start_bit", int'(TX), 0);
            end else if (b <= 8) begin
               dec_byte[b-1] = TX;
            end else begin
               check("stop_bit", int'(TX), 1);
               rx_q.push_back(dec_byte);
               dec_busy = 1'b0;
            end
         end
      end
   endfunction

   task automatic tick(input logic wr, input logic [7:0] d);
      WR = wr;
      D  = d;
      @(posedge CLK);
      if (RST_N) model_step(wr, d);
      @(negedge CLK);
      compare_all();
      decode();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      model_reset();
      check("rst_tx", int'(TX), 1);
      check("rst_txe", int'(TXE), 1);
      check("rst_count", int'(COUNT), 0);
      check("rst_full", int'(FULL), 0);
      check("rst_ovf", int'(OVF), 0);
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      RST_N = 1'b1;
   endtask

   task automatic wait_txe(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick(1'b0, 8'h00);
         if (TXE) done = 1'b1;
      end
      check("txe_wait", int'(done), 1);
   endtask

   task automatic wait_fpos(input int pos, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (m_busy && m_fpos == pos) done = 1'b1;
         else tick(1'b0, 8'h00);
      end
      check("fpos_wait", int'(done), 1);
   endtask

   task automatic check_stream();
      check("stream_len", rx_q.size(), acc_q.size());
      for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++)
         check("stream_byte", int'(rx_q[i]), int'(acc_q[i]));
      rx_q.delete();
      acc_q.delete();
   endtask

   initial begin
      vec_t vecs[5];
      int   lows;
      int   txe_hi;
      int   gap;

      vecs[0] = '{d: 8'h55, frame: 10'b1_01010101_0};
      vecs[1] = '{d: 8'h00, frame: 10'b1_00000000_0};
      vecs[2] = '{d: 8'hFF, frame: 10'b1_11111111_0};
      vecs[3] = '{d: 8'h3C, frame: 10'b1_00111100_0};
      vecs[4] = '{d: 8'h81, frame: 10'b1_10000001_0};

      do_reset();

      // Single frames: start at k+1, mid-bit levels, TXE back at k+101.
      for (int v = 0; v < 5; v++) begin
         tick(1'b1, vecs[v].d);
         check("vec_k_tx", int'(TX), 1);
         check("vec_k_txe", int'(TXE), 0);
         for (int n = 1; n <= FRAME + 1; n++) begin
            tick(1'b0, 8'h00);
            if (n == 1) check("vec_first_low", int'(TX), 0);
            if (n % DIV == DIV / 2 + 1) check("vec_bit", int'(TX), int'(vecs[v].frame[(n - 1) / DIV]));
            if (n == FRAME) check("vec_txe_busy", int'(TXE), 0);
            if (n == FRAME + 1) check("vec_txe_done", int'(TXE), 1);
         end
         check("vec_rx_len", rx_q.size(), 1);
         if (rx_q.size() > 0) check("vec_rx_byte", int'(rx_q[0]), int'(vecs[v].d));
         check_stream();
      end

      // Three consecutive pushes: contiguous 300-cycle burst.
      tick(1'b1, 8'hA5);
      check("t2_cnt0", int'(COUNT), 1);
      tick(1'b1, 8'h00);
      check("t2_cnt1", int'(COUNT), 1);
      tick(1'b1, 8'hFF);
      check("t2_cnt2", int'(COUNT), 2);
      txe_hi = 0;
      for (int i = 0; i < 3 * FRAME - 2; i++) begin
         tick(1'b0, 8'h00);
         if (TXE) txe_hi++;
      end
      check("t2_no_gap", txe_hi, 0);
      tick(1'b0, 8'h00);
      check("t2_txe_end", int'(TXE), 1);
      check("t2_rx_len", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         check("t2_rx0", int'(rx_q[0]), 8'hA5);
         check("t2_rx1", int'(rx_q[1]), 8'h00);
         check("t2_rx2", int'(rx_q[2]), 8'hFF);
      end
      check_stream();

      // Overflow: 20 pushes, bytes 17..19 dropped.
      do_reset();
      for (int i = 0; i < 20; i++) tick(1'b1, 8'(i));
      check("t3_ovf", int'(OVF), 1);
      check("t3_full", int'(FULL), 1);
      check("t3_count", int'(COUNT), 16);
      wait_txe(17 * FRAME + 50);
      check("t3_rx_len", rx_q.size(), 17);
      for (int i = 0; i < rx_q.size(); i++) check("t3_rx_byte", int'(rx_q[i]), i);
      check("t3_ovf_sticky", int'(OVF), 1);
      rx_q.delete();
      acc_q.delete();

      // Push while full exactly at the end of a stop bit.
      do_reset();
      for (int i = 0; i < 17; i++) tick(1'b1, 8'(8'h10 + i));
      wait_fpos(FRAME - 1, 2 * FRAME);
      check("t4_full_before", int'(FULL), 1);
      tick(1'b1, 8'hC3);
      check("t4_count", int'(COUNT), 16);
      check("t4_ovf", int'(OVF), 0);
      check("t4_full_after", int'(FULL), 1);
      check("t4_start", int'(TX), 0);
      wait_txe(18 * FRAME + 50);
      check("t4_rx_len", rx_q.size(), 18);
      if (rx_q.size() == 18) check("t4_rx_last", int'(rx_q[17]), 8'hC3);
      check_stream();

      // Reset in DATA bit 3 of 0x3C, then in a low data bit of 0x00.
      tick(1'b1, 8'h3C);
      tick(1'b1, 8'h11);
      tick(1'b1, 8'h22);
      wait_fpos(4 * DIV + 5, 2 * FRAME);
      check("t5_count_pre", int'(COUNT), 2);
      do_reset();
      tick(1'b1, 8'h00);
      wait_fpos(2 * DIV + 5, 2 * FRAME);
      check("t5_low_pre", int'(TX), 0);
      do_reset();
      lows = 0;
      for (int i = 0; i < 30 * DIV; i++) begin
         tick(1'b0, 8'h00);
         if (!TX) lows++;
      end
      check("t5_quiet", lows, 0);
      tick(1'b1, 8'h5A);
      wait_txe(FRAME + 20);
      check("t5_rx_len", rx_q.size(), 1);
      if (rx_q.size() > 0) check("t5_rx_byte", int'(rx_q[0]), 8'h5A);
      check_stream();

      // Random gaps, never pushing into a full FIFO.
      do_reset();
      for (int n = 0; n < 60; n++) begin
         gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 150));
         for (int g = 0; g < gap; g++) tick(1'b0, 8'h00);
         if (q.size() < DEPTH) tick(1'b1, 8'($urandom));
         else                  tick(1'b0, 8'h00);
      end
      wait_txe(DEPTH * FRAME + 100);
      check("t6_ovf", int'(OVF), 0);
      check_stream();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
